// File: rtl/h2l_pkg.sv
// Shared types and sizing helpers for the h2l word-to-lane unpacker.
package h2l_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } h2l_state_e;

  function automatic int h2l_ratio(input int data_width, input int out_width);
    return data_width / out_width;
  endfunction

  // Floor of 1 bit keeps declarations legal long enough for the ratio check to fire.
  function automatic int h2l_lane_w(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/h2l_unpacker_if.sv
// FIFO-read and lane-output signal bundle; master is the unpacker side.
interface h2l_unpacker_if
  import h2l_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic                  empty;
  logic                  ren;
  logic [DATA_WIDTH-1:0] din;
  logic [OUT_WIDTH-1:0]  dout;
  logic                  dvalid;
  logic                  dready;
  logic                  last;
  logic                  busy;

  modport master (
    input  empty, din, dready,
    output ren, dout, dvalid, last, busy
  );

  modport slave (
    output empty, din, dready,
    input  ren, dout, dvalid, last, busy
  );
endinterface

// File: rtl/h2l_lane_sel.sv
// Combinational lane mux; H2L_MSB_FIRST_EN flips lane order to MSB-first.
module h2l_lane_sel
  import h2l_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int RATIO      = h2l_ratio(DATA_WIDTH, OUT_WIDTH),
  parameter int LANE_W     = h2l_lane_w(RATIO)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [LANE_W-1:0]     lane,
  input  logic                  en,
  output logic [OUT_WIDTH-1:0]  lane_data
);
  logic [OUT_WIDTH-1:0] lanes [RATIO];
  logic [LANE_W-1:0]    sel;

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign lanes[k] = word[k*OUT_WIDTH +: OUT_WIDTH];
  end

  always_comb begin
`ifdef H2L_MSB_FIRST_EN
    sel = LANE_W'(RATIO - 1) - lane;
`else
    sel = lane;
`endif
    lane_data = en ? lanes[sel] : '0;
  end
endmodule

// File: rtl/h2l_unpacker.sv
// Pops one FIFO word and streams it out as RATIO lanes with valid/ready.
// Lane order: LSB-first by default, MSB-first when H2L_MSB_FIRST_EN is defined.
//
// state | meaning
// IDLE  | waiting for a FIFO entry; ren follows !empty
// FETCH | popped word arriving on din, captured into hold register
// SEND  | presenting lanes of the held word, advancing on dready
module h2l_unpacker
  import h2l_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input logic            rclk,
  input logic            rst,
  h2l_unpacker_if.master bus
);
  localparam int RATIO  = h2l_ratio(DATA_WIDTH, OUT_WIDTH);
  localparam int LANE_W = h2l_lane_w(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_cfg_check
    $fatal(1, "h2l_unpacker: DATA_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
  end

  h2l_state_e            state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  dvalid_q, dvalid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.empty) state_d = FETCH;
      end
      FETCH: begin
        hold_d  = bus.din;
        lane_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (bus.dready) begin
          if (lane_q == LAST_LANE) state_d = IDLE;
          else                     lane_d  = lane_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    dvalid_d = (state_d == SEND);
    last_d   = dvalid_d && (lane_d == LAST_LANE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      hold_q   <= '0;
      dvalid_q <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      hold_q   <= hold_d;
      dvalid_q <= dvalid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  // rst gates ren so no pop can slip out while the block is held in reset.
  assign bus.ren    = !rst && (state_q == IDLE) && !bus.empty;
  assign bus.dvalid = dvalid_q;
  assign bus.last   = last_q;
  assign bus.busy   = busy_q;

  h2l_lane_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_lane_sel (
    .word      (hold_q),
    .lane      (lane_q),
    .en        (dvalid_q),
    .lane_data (bus.dout)
  );
endmodule
